// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control sequencer with memory ready handshake and retired-instruction counter.
// Optional: define ILLEGAL_TRAP_EN to halt in TRAP on illegal decode instead of retiring it as a NOP.
module multicycle_ctrl #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr,
   input  logic                 eq,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           alu_ctrl,
   output logic [2:0]           imm_src,
   output logic [1:0]           result_src,
   output logic [INSTRET_W-1:0] instret,
   output logic                 trap
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
      S_JALR_LINK, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_PASS = 3'b111;

   state_t                 state_reg, state_next;
   logic [INSTRET_W-1:0]   instret_reg;
   logic                   retire;
   logic                   illegal;
   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic                   funct7b;
   logic                   unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign funct7b           = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
   assign instret           = instret_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_FETCH;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (retire)
            instret_reg <= instret_reg + INSTRET_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      imm_src    = 3'b000;
      result_src = 2'b00;
      trap       = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state_reg)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch/jump target is precomputed into ALUOut here.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
               OP_R:              state_next = S_EXEC_R;
               OP_I:              state_next = S_EXEC_I;
               OP_LUI:            state_next = S_LUI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               default:           illegal    = 1'b1;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a  = 2'b10;
            state_next = S_ALU_WB;
            case (funct3)
               3'b000:  alu_ctrl = funct7b ? ALU_SUB : ALU_ADD;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: illegal  = 1'b1;
            endcase
         end
         S_EXEC_I: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = S_ALU_WB;
            case (funct3)
               3'b000:  alu_ctrl = ALU_ADD;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: illegal  = 1'b1;
            endcase
         end
         S_LUI: begin
            alu_src_b  = 2'b01;
            imm_src    = 3'b100;
            alu_ctrl   = ALU_PASS;
            state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            imm_src    = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready)
               state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a  = 2'b10;
            alu_ctrl   = ALU_SUB;
            retire     = 1'b1;
            state_next = S_FETCH;
            case (funct3)
               3'b000:  pc_write = eq;
               3'b001:  pc_write = ~eq;
               default: illegal  = 1'b1;
            endcase
         end
         S_JAL: begin
            // Jump to the DECODE target while computing the link value OldPC+4.
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_write   = 1'b1;
            state_next = S_ALU_WB;
         end
         S_JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_next = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: begin
            trap = 1'b1;
         end
`endif
         default: state_next = S_FETCH;
      endcase

      if (illegal) begin
         pc_write  = 1'b0;
         reg_write = 1'b0;
`ifdef ILLEGAL_TRAP_EN
         retire     = 1'b0;
         state_next = S_TRAP;
`else
         retire     = 1'b1;
         state_next = S_FETCH;
`endif
      end

      // Reset forces every output low, including the FETCH request.
      if (!rst_n) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_ctrl   = ALU_ADD;
         imm_src    = 3'b000;
         result_src = 2'b00;
         trap       = 1'b0;
         retire     = 1'b0;
         state_next = S_FETCH;
      end
   end

endmodule
